// File: rtl/traffic_light_fsm.sv
// Two-road traffic-light controller: NS/EW green/yellow/red cycling paced by a 1 s strobe,
// a two-digit BCD countdown display, and a flashing-yellow night mode.
module traffic_light_fsm #(
  parameter int unsigned T_GREEN  = 25,
  parameter int unsigned T_YELLOW = 5
) (
  input  logic       clk100M,
  input  logic       rst,
  input  logic       tick_1s,
  input  logic       night,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic [3:0] cnt_tens,
  output logic [3:0] cnt_ones,
  output logic       div_clr
);

  typedef enum logic [2:0] {NS_G, NS_Y, EW_G, EW_Y, NIGHT} state_e;

  localparam logic [6:0] GREEN_LEN  = 7'(T_GREEN);
  localparam logic [6:0] YELLOW_LEN = 7'(T_YELLOW);
  localparam logic [3:0] GREEN_TENS = 4'(T_GREEN / 10);
  localparam logic [3:0] GREEN_ONES = 4'(T_GREEN % 10);

  localparam logic [2:0] L_RED    = 3'b100;
  localparam logic [2:0] L_YELLOW = 3'b010;
  localparam logic [2:0] L_GREEN  = 3'b001;

  state_e     state_q, state_d;
  logic [6:0] cnt_q, cnt_d;
  logic       blink_q, blink_d;
  logic       clr_q, clr_d;
  logic [2:0] ns_q, ns_d, ew_q, ew_d;
  logic [3:0] tens_q, tens_d, ones_q, ones_d;

  // Split 0..99 into BCD digits by repeated subtraction of ten.
  function automatic logic [7:0] to_bcd(input logic [6:0] value);
    logic [6:0] rem;
    logic [3:0] tens;
    rem  = value;
    tens = 4'd0;
    for (int i = 0; i < 9; i++) begin
      if (rem >= 7'd10) begin
        rem  = rem - 7'd10;
        tens = tens + 4'd1;
      end
    end
    return {tens, rem[3:0]};
  endfunction

  // NOTE: combinational next-state logic uses blocking assignments with a default
  // for every target first, so no latch can be inferred; state registers use <=.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    blink_d = blink_q;
    clr_d   = 1'b0;

    if (state_q == NIGHT) begin
      if (!night) begin
        state_d = NS_G;
        cnt_d   = GREEN_LEN;
        blink_d = 1'b0;
        clr_d   = 1'b1;
      end else if (tick_1s) begin
        blink_d = ~blink_q;
      end
    end else if (night) begin
      state_d = NIGHT;
      cnt_d   = 7'd0;
      blink_d = 1'b0;
    end else if (tick_1s) begin
      if (cnt_q == 7'd1) begin
        case (state_q)
          NS_G:    begin state_d = NS_Y; cnt_d = YELLOW_LEN; end
          NS_Y:    begin state_d = EW_G; cnt_d = GREEN_LEN;  end
          EW_G:    begin state_d = EW_Y; cnt_d = YELLOW_LEN; end
          default: begin state_d = NS_G; cnt_d = GREEN_LEN;  end
        endcase
      end else begin
        cnt_d = cnt_q - 7'd1;
      end
    end
  end

  // Outputs are decoded from the next state so the registered lights and digits
  // change on the same edge as the state itself.
  always_comb begin
    case (state_d)
      NS_G:    begin ns_d = L_GREEN;  ew_d = L_RED;    end
      NS_Y:    begin ns_d = L_YELLOW; ew_d = L_RED;    end
      EW_G:    begin ns_d = L_RED;    ew_d = L_GREEN;  end
      EW_Y:    begin ns_d = L_RED;    ew_d = L_YELLOW; end
      NIGHT:   begin ns_d = {1'b0, blink_d, 1'b0}; ew_d = {1'b0, blink_d, 1'b0}; end
      default: begin ns_d = L_RED;    ew_d = L_RED;    end
    endcase
    {tens_d, ones_d} = to_bcd(cnt_d);
  end

  always_ff @(posedge clk100M) begin
    if (rst) begin
      state_q <= NS_G;
      cnt_q   <= GREEN_LEN;
      blink_q <= 1'b0;
      clr_q   <= 1'b1;
      ns_q    <= L_GREEN;
      ew_q    <= L_RED;
      tens_q  <= GREEN_TENS;
      ones_q  <= GREEN_ONES;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      blink_q <= blink_d;
      clr_q   <= clr_d;
      ns_q    <= ns_d;
      ew_q    <= ew_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
    end
  end

  assign ns_light = ns_q;
  assign ew_light = ew_q;
  assign cnt_tens = tens_q;
  assign cnt_ones = ones_q;
  assign div_clr  = clr_q;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Scoreboard bench for traffic_light_fsm: stimulus pushes per-edge expectations,
// a monitor pops and compares them one time unit after each rising edge.
module tb_traffic_light_fsm;

  localparam int TG = 25;
  localparam int TY = 5;

  logic       clk100M = 1'b0;
  logic       rst, tick_1s, night;
  logic [2:0] ns_light, ew_light;
  logic [3:0] cnt_tens, cnt_ones;
  logic       div_clr;

  traffic_light_fsm #(.T_GREEN(TG), .T_YELLOW(TY)) dut (
    .clk100M  (clk100M),
    .rst      (rst),
    .tick_1s  (tick_1s),
    .night    (night),
    .ns_light (ns_light),
    .ew_light (ew_light),
    .cnt_tens (cnt_tens),
    .cnt_ones (cnt_ones),
    .div_clr  (div_clr)
  );

  always #5 clk100M = ~clk100M;

  typedef struct {
    int          tag;
    string       name;
    logic [14:0] value;   // {ns, ew, tens, ones, div_clr}
  } exp_t;

  exp_t sb[$];
  int   edge_cnt = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at edge %0d: got %b, expected %b", name, edge_cnt, act, exp);
  endtask

  // Reference model: phase 0..3 = NS_G, NS_Y, EW_G, EW_Y; phase 4 = night.
  int       m_ph = 0, m_cnt = TG;
  bit       m_blink = 1'b0, m_clr = 1'b1;
  logic [2:0] ns_tab [4] = '{3'b001, 3'b010, 3'b100, 3'b100};
  logic [2:0] ew_tab [4] = '{3'b100, 3'b100, 3'b001, 3'b010};
  int         dur_tab[4] = '{TG, TY, TG, TY};

  task automatic model_edge(input bit r, input bit t, input bit n);
    if (r) begin
      m_ph = 0; m_cnt = TG; m_blink = 1'b0; m_clr = 1'b1;
    end else if (m_ph == 4) begin
      m_clr = 1'b0;
      if (!n) begin
        m_ph = 0; m_cnt = TG; m_blink = 1'b0; m_clr = 1'b1;
      end else if (t) m_blink = ~m_blink;
    end else begin
      m_clr = 1'b0;
      if (n) begin
        m_ph = 4; m_cnt = 0; m_blink = 1'b0;
      end else if (t) begin
        if (m_cnt == 1) begin
          m_ph  = (m_ph + 1) % 4;
          m_cnt = dur_tab[m_ph];
        end else m_cnt = m_cnt - 1;
      end
    end
  endtask

  function automatic logic [14:0] model_out();
    logic [2:0] ns, ew;
    if (m_ph == 4) begin
      ns = {1'b0, m_blink, 1'b0};
      ew = ns;
    end else begin
      ns = ns_tab[m_ph];
      ew = ew_tab[m_ph];
    end
    return {ns, ew, 4'(m_cnt / 10), 4'(m_cnt % 10), m_clr};
  endfunction

  task automatic push(input string name, input logic [14:0] value);
    exp_t e;
    e.tag   = edge_cnt + 1;
    e.name  = name;
    e.value = value;
    sb.push_back(e);
  endtask

  // One clock of stimulus, expectation from the model.
  task automatic step(input bit r, input bit t, input bit n, input string name);
    @(negedge clk100M);
    rst = r; tick_1s = t; night = n;
    model_edge(r, t, n);
    push(name, model_out());
  endtask

  // One clock of stimulus, expectation written out by hand.
  task automatic step_h(input bit r, input bit t, input bit n, input string name,
                        input logic [2:0] ns, input logic [2:0] ew,
                        input logic [3:0] tens, input logic [3:0] ones, input logic clr);
    @(negedge clk100M);
    rst = r; tick_1s = t; night = n;
    model_edge(r, t, n);
    push(name, {ns, ew, tens, ones, clr});
  endtask

  task automatic ticks(input int count, input int gap, input string name);
    for (int k = 0; k < count; k++) begin
      for (int g = 1; g < gap; g++) step(1'b0, 1'b0, 1'b0, name);
      step(1'b0, 1'b1, 1'b0, name);
    end
  endtask

  // Monitor: every rising edge is a presented output; compare when an expectation exists.
  initial begin
    exp_t e;
    logic bad;
    forever begin
      @(posedge clk100M);
      edge_cnt++;
      #1;
      while (sb.size() > 0 && sb[0].tag < edge_cnt) begin
        e = sb.pop_front();
        check({e.name, "_missed"}, 15'd0, 15'h7fff);
      end
      if (sb.size() > 0 && sb[0].tag == edge_cnt) begin
        e = sb.pop_front();
        check(e.name, {ns_light, ew_light, cnt_tens, cnt_ones, div_clr}, e.value);
        bad = (ns_light[0] && ew_light != 3'b100) || (ew_light[0] && ns_light != 3'b100) ||
              (ns_light[1] && ew_light != 3'b100 && ew_light != 3'b010) ||
              (ew_light[1] && ns_light != 3'b100 && ns_light != 3'b010);
        check({e.name, "_conflict"}, {14'd0, bad}, 15'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit nt;
    rst = 1'b1; tick_1s = 1'b0; night = 1'b0;

    // 1. Reset for three clocks, then release.
    for (int i = 0; i < 3; i++) step_h(1, 0, 0, "rst_hold", 3'b001, 3'b100, 4'd2, 4'd5, 1'b1);
    step_h(0, 0, 0, "rst_release", 3'b001, 3'b100, 4'd2, 4'd5, 1'b0);
    step_h(0, 0, 0, "rst_idle",    3'b001, 3'b100, 4'd2, 4'd5, 1'b0);

    // 2. Full cycle with a tick every 10 clocks; back in NS_G 25 after 60 ticks.
    ticks(60, 10, "full_cycle");
    step_h(0, 0, 0, "cycle_back", 3'b001, 3'b100, 4'd2, 4'd5, 1'b0);

    // 3. Walk to EW_Y with 01 showing, then the wrap tick.
    ticks(59, 1, "to_ewy");
    step_h(0, 0, 0, "ewy_at_01", 3'b100, 3'b010, 4'd0, 4'd1, 1'b0);
    step_h(0, 1, 0, "ewy_wrap",  3'b001, 3'b100, 4'd2, 4'd5, 1'b0);
    for (int i = 0; i < 1000; i++) step(0, 0, 0, "no_tick_hold");
    step_h(0, 0, 0, "hold_end", 3'b001, 3'b100, 4'd2, 4'd5, 1'b0);

    // 4. Night entry at display 17 with a coincident tick, then blinking.
    ticks(8, 3, "to_17");
    step_h(0, 0, 0, "at_17",     3'b001, 3'b100, 4'd1, 4'd7, 1'b0);
    step_h(0, 1, 1, "night_in",  3'b000, 3'b000, 4'd0, 4'd0, 1'b0);
    step_h(0, 0, 1, "night_idle",3'b000, 3'b000, 4'd0, 4'd0, 1'b0);
    step_h(0, 1, 1, "blink_on",  3'b010, 3'b010, 4'd0, 4'd0, 1'b0);
    step_h(0, 0, 1, "blink_hold",3'b010, 3'b010, 4'd0, 4'd0, 1'b0);
    step_h(0, 1, 1, "blink_off", 3'b000, 3'b000, 4'd0, 4'd0, 1'b0);
    step_h(0, 1, 1, "blink_on2", 3'b010, 3'b010, 4'd0, 4'd0, 1'b0);

    // 5. Night exit with a coincident tick: tick ignored, one-cycle div_clr.
    step_h(0, 1, 0, "night_out", 3'b001, 3'b100, 4'd2, 4'd5, 1'b1);
    step_h(0, 0, 0, "clr_drop",  3'b001, 3'b100, 4'd2, 4'd5, 1'b0);
    step_h(0, 1, 0, "tick_24",   3'b001, 3'b100, 4'd2, 4'd4, 1'b0);

    // 6. Reset mid-EW_Y (display 03) and again in NIGHT.
    ticks(56, 2, "to_ewy_mid");
    step_h(0, 0, 0, "ewy_03",      3'b100, 3'b010, 4'd0, 4'd3, 1'b0);
    step_h(1, 1, 0, "rst_ewy",     3'b001, 3'b100, 4'd2, 4'd5, 1'b1);
    step_h(0, 0, 0, "rst_ewy_rel", 3'b001, 3'b100, 4'd2, 4'd5, 1'b0);
    step(0, 0, 1, "enter_night");
    step(0, 1, 1, "night_blink");
    step_h(1, 1, 1, "rst_night",     3'b001, 3'b100, 4'd2, 4'd5, 1'b1);
    step_h(0, 0, 0, "rst_night_rel", 3'b001, 3'b100, 4'd2, 4'd5, 1'b0);

    // Random soak of ticks and night toggles.
    nt = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(59) == 0) nt = ~nt;
      step(0, ($urandom_range(3) == 0), nt, "soak");
    end

    repeat (3) @(negedge clk100M);
    check("scoreboard_drained", 15'(sb.size()), 15'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
